bus_trace_monitor: RTL
======================

// Module: bus_trace_monitor
// PURPOSE
//  Synthesizable, parametrised monitor for the CPU<->MEMORY bus (MAR, data to/from memory, EN, CS).
//  Replaces ad-hoc $display tracing and fixed-delay $finish in benches.
//  Captures each memory transaction into a trace FIFO and keeps read/write statistics.
//  Raises a sticky halt after a programmable cycle budget.
//  Sits in parallel with the bus: inputs only toward CPU/MEMORY, never drives them.
// PARAMETERS
//  ADDR_W       8    address (MAR) width
//  DATA_W       16   data bus width
//  DEPTH        16   trace FIFO entries; power of 2, >=2
//  CNT_W        16   width of cycle counter and statistics counters
//  STOP_CYCLES  220  cycle budget before halt; 0 = never halt
// PORTS
//  clock        in   1                   system clock, rising edge
//  reset        in   1                   asynchronous, active-high reset
//  mon_addr     in   ADDR_W              MAR as driven by CPU
//  mon_wdata    in   DATA_W              data from CPU into memory
//  mon_rdata    in   DATA_W              data from memory into CPU
//  mon_en       in   1                   memory EN (1 = write, 0 = read)
//  mon_cs       in   1                   memory chip select (1 = access active)
//  pop_ready    in   1                   consumer accepts head entry this cycle
//  pop_valid    out  1                   FIFO not empty
//  pop_data     out  1+ADDR_W+DATA_W(+CNT_W)  head entry {we, addr, data[, stamp]}
//  overflow     out  1                   sticky: at least one entry dropped
//  wr_count     out  CNT_W               captured writes, saturating
//  rd_count     out  CNT_W               captured reads, saturating
//  cycle_count  out  CNT_W               cycles since reset, saturating
//  halt         out  1                   sticky: cycle budget exhausted
// BEHAVIOUR
//  - Reset (async, active-high): FIFO emptied, pointers 0, all counters 0, overflow=0, halt=0, pop_valid=0.
//  - Registered snapshot of the previous cycle: prev_cs, prev_addr, prev_en.
//  - Capture event at rising edge when mon_cs=1, halt=0, and any of:
//    prev_cs=0, mon_addr!=prev_addr, mon_en!=prev_en.
//    A CS held high on one address/direction is exactly one transaction.
//  - Entry contents:
//    we=mon_en; addr=mon_addr; data=mon_en ? mon_wdata : mon_rdata.
//    All fields sampled in the capture cycle.
//  - Capture event also increments wr_count (we=1) or rd_count (we=0); both saturate at all-ones.
//  - FIFO write: entry visible on pop_valid/pop_data the cycle after capture (latency 1).
//  - pop_data always shows the head entry, read first-word-fall-through.
//  - Pop handshake: head removed on the rising edge where pop_valid && pop_ready.
//  - Full FIFO with no pop in the same cycle: new entry is dropped and overflow is set (sticky until reset).
//    Statistics counters still increment.
//  - Full FIFO with pop in the same cycle: pop and push both occur; no drop.
//  - Empty FIFO: pop_ready is ignored; pointers unchanged.
//  - Pointers are log2(DEPTH) bits plus a wrap bit, and wrap naturally.
//    full = equal index with differing wrap bit.
//  - cycle_count: increments every cycle after reset, saturates, freezes once halt=1.
//  - halt: set on the edge where cycle_count == STOP_CYCLES-1 and STOP_CYCLES != 0.
//    After halt, no new captures occur; popping continues normally.
//  - Reset asserted mid-transaction: all state cleared immediately.
//    The first cycle after release with mon_cs=1 counts as a new transaction, since prev_cs resets to 0.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined:
//    each entry gets a low CNT_W field holding the cycle_count value at capture.
//    pop_data width is 1+ADDR_W+DATA_W+CNT_W.
//  TRACE_TIMESTAMP_EN undefined:
//    no stamp field; pop_data width is 1+ADDR_W+DATA_W.
//    Behaviour is otherwise identical.
// TESTING
//  1. Reset with DEPTH=16 -> all outputs 0.
//     Release reset, then idle 10 cycles -> cycle_count=10, pop_valid=0.
//  2. Write: CS=1, EN=1, MAR=4, wdata=96, held 3 cycles -> exactly one entry {1,8'd4,16'd96}; wr_count=1.
//     With TRACE_TIMESTAMP_EN, stamp = capture cycle.
//  3. Read: CS=1, EN=0, MAR 4 then MAR 5 back-to-back, rdata 96 then 7 -> two entries {0,4,96} and {0,5,7}; rd_count=2.
//  4. 17 distinct accesses with pop_ready=0 -> 16 entries; overflow=1; counts total 17.
//     Then pop all 16 -> entries in order; pop_valid=0.
//  5. FIFO full, capture and pop in the same cycle -> overflow stays 0; occupancy stays 16; head advances.
//  6. STOP_CYCLES=220 -> halt=1 at cycle 220; cycle_count frozen at 220; later CS activity not captured.
//     Assert reset mid-access -> everything clears.

Source files
------------

// File: rtl/bus_trace_monitor.sv
// Passive CPU<->memory bus tracer: trace FIFO, read/write statistics, cycle-budget halt.
// Define TRACE_TIMESTAMP_EN to append a cycle_count stamp to every trace entry.
module bus_trace_monitor #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int STOP_CYCLES = 220,
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W    = 1 + ADDR_W + DATA_W + CNT_W
`else
    localparam int ENTRY_W    = 1 + ADDR_W + DATA_W
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  mon_addr,
    input  logic [DATA_W-1:0]  mon_wdata,
    input  logic [DATA_W-1:0]  mon_rdata,
    input  logic               mon_en,
    input  logic               mon_cs,
    input  logic               pop_ready,
    output logic               pop_valid,
    output logic [ENTRY_W-1:0] pop_data,
    output logic               overflow,
    output logic [CNT_W-1:0]   wr_count,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               halt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
    localparam bit HALT_EN = (STOP_CYCLES != 0);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wptr;
    logic [AW:0]        rptr;
    logic               prev_cs;
    logic               prev_en;
    logic [ADDR_W-1:0]  prev_addr;

    logic               empty;
    logic               full;
    logic               capture;
    logic               pop_fire;
    logic               push;
    logic [ENTRY_W-1:0] entry;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    // One transaction per CS-high run on a fixed address and direction.
    assign capture  = mon_cs && !halt &&
                      (!prev_cs || (mon_addr != prev_addr) || (mon_en != prev_en));
    assign pop_fire = !empty && pop_ready;
    assign push     = capture && (!full || pop_fire);

`ifdef TRACE_TIMESTAMP_EN
    assign entry = {mon_en, mon_addr, mon_en ? mon_wdata : mon_rdata, cycle_count};
`else
    assign entry = {mon_en, mon_addr, mon_en ? mon_wdata : mon_rdata};
`endif

    assign pop_valid = !empty;
    assign pop_data  = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            prev_cs   <= 1'b0;
            prev_en   <= 1'b0;
            prev_addr <= '0;
        end else begin
            prev_cs   <= mon_cs;
            prev_en   <= mon_en;
            prev_addr <= mon_addr;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_fire) begin
                rptr <= rptr + 1'b1;
            end
            if (capture && full && !pop_fire) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (capture) begin
            if (mon_en && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
            if (!mon_en && (rd_count != '1)) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            halt        <= 1'b0;
        end else if (!halt) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (HALT_EN && (cycle_count == STOP_LAST)) begin
                halt <= 1'b1;
            end
        end
    end

endmodule
